// File: rtl/sys_cmd_ctrl_if.sv
// sys_cmd_ctrl_if
//   Bundles the byte-frame, register-file, ALU and TX FIFO signals of the
//   command decoder.
//   master : the command decoder (consumes RX/RF/ALU/FIFO status, drives strobes)
//   slave  : the surrounding system (UART RX, register file, ALU, TX FIFO)
//   Signals:
//     rx_p_data/rx_d_vld           received byte and its one-cycle strobe
//     rf_rd_data/rf_rd_data_vld    register-file read return
//     alu_out/alu_out_vld          ALU result return
//     fifo_full                    TX FIFO back-pressure
//     rf_addr/rf_wr_en/rf_rd_en/rf_wr_data   register-file access
//     alu_func/alu_en/clk_gate_en  ALU control
//     tx_p_data/tx_d_vld           TX FIFO push
//     cmd_err                      unknown opcode / timeout pulse
interface sys_cmd_ctrl_if #(
  parameter int FRAME_WIDTH         = 8,
  parameter int ALU_DATA_WIDTH      = 16,
  parameter int ALU_FUNC_WIDTH      = 4,
  parameter int REG_FILE_ADDR_WIDTH = 4
);
  logic [FRAME_WIDTH-1:0]         rx_p_data;
  logic                           rx_d_vld;
  logic [FRAME_WIDTH-1:0]         rf_rd_data;
  logic                           rf_rd_data_vld;
  logic [ALU_DATA_WIDTH-1:0]      alu_out;
  logic                           alu_out_vld;
  logic                           fifo_full;
  logic [REG_FILE_ADDR_WIDTH-1:0] rf_addr;
  logic                           rf_wr_en;
  logic                           rf_rd_en;
  logic [FRAME_WIDTH-1:0]         rf_wr_data;
  logic [ALU_FUNC_WIDTH-1:0]      alu_func;
  logic                           alu_en;
  logic                           clk_gate_en;
  logic [FRAME_WIDTH-1:0]         tx_p_data;
  logic                           tx_d_vld;
  logic                           cmd_err;

  modport master (
    input  rx_p_data, rx_d_vld, rf_rd_data, rf_rd_data_vld,
           alu_out, alu_out_vld, fifo_full,
    output rf_addr, rf_wr_en, rf_rd_en, rf_wr_data,
           alu_func, alu_en, clk_gate_en, tx_p_data, tx_d_vld, cmd_err
  );

  modport slave (
    output rx_p_data, rx_d_vld, rf_rd_data, rf_rd_data_vld,
           alu_out, alu_out_vld, fifo_full,
    input  rf_addr, rf_wr_en, rf_rd_en, rf_wr_data,
           alu_func, alu_en, clk_gate_en, tx_p_data, tx_d_vld, cmd_err
  );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl
//   Command decoder between the UART receive path and the register file/ALU.
//   Parses byte frames into write, read and ALU commands, issues one-cycle
//   register-file/ALU strobes and pushes results into the TX FIFO.
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous active-high reset
//     bus  sys_cmd_ctrl_if.master (RX frames, RF/ALU control, TX FIFO push)
//   Optional feature: define SYS_CTRL_TIMEOUT_EN to add an inter-frame
//   watchdog that aborts a stalled command after TIMEOUT_CYCLES cycles.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | waiting for an opcode frame
//   WR_ADDR  | write: waiting for the address frame
//   WR_DATA  | write: waiting for the data frame
//   RD_ADDR  | read: waiting for the address frame
//   RD_WAIT  | read: waiting for register-file read data
//   ALU_A    | ALU: operand A frame, written to reg 0
//   ALU_B    | ALU: operand B frame, written to reg 1
//   ALU_FN   | ALU: function frame, starts the ALU
//   ALU_WAIT | ALU: waiting for the result
//   TX_LO    | pushing result low byte
//   TX_HI    | pushing result high byte (ALU results only)
module sys_cmd_ctrl #(
  parameter int FRAME_WIDTH         = 8,
  parameter int ALU_DATA_WIDTH      = 16,
  parameter int ALU_FUNC_WIDTH      = 4,
  parameter int REG_FILE_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES      = 4096
) (
  input  logic          clk,
  input  logic          rst,
  sys_cmd_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
    ALU_A, ALU_B, ALU_FN, ALU_WAIT, TX_LO, TX_HI
  } state_t;

  localparam logic [FRAME_WIDTH-1:0] OP_WR  = FRAME_WIDTH'(8'hAA);
  localparam logic [FRAME_WIDTH-1:0] OP_RD  = FRAME_WIDTH'(8'hBB);
  localparam logic [FRAME_WIDTH-1:0] OP_ALU = FRAME_WIDTH'(8'hCC);
  localparam logic [FRAME_WIDTH-1:0] OP_FN  = FRAME_WIDTH'(8'hDD);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t                         state_q, state_d;
  logic [REG_FILE_ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [FRAME_WIDTH-1:0]         rf_wr_data_q, rf_wr_data_d;
  logic                           rf_wr_en_q, rf_wr_en_d;
  logic                           rf_rd_en_q, rf_rd_en_d;
  logic [ALU_FUNC_WIDTH-1:0]      alu_func_q, alu_func_d;
  logic                           alu_en_q, alu_en_d;
  logic                           cmd_err_q, cmd_err_d;
  logic [ALU_DATA_WIDTH-1:0]      res_q, res_d;
  logic                           is_alu_q, is_alu_d;
  logic                           tx_push;
  // accept: a frame or return value consumed this cycle; restarts the watchdog
  logic                           accept;
  logic                           timeout_hit;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt_q;
  logic             waiting;

  assign waiting = (state_q != IDLE) && (state_q != TX_LO) && (state_q != TX_HI);

  // Down-counter holds the cycles left until abort; terminal count 1 means the
  // next edge lands exactly TIMEOUT_CYCLES cycles after the last accepted input.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= CNT_LOAD;
    end else if (accept) begin
      to_cnt_q <= CNT_LOAD;
    end else if (waiting && (to_cnt_q != '0)) begin
      to_cnt_q <= to_cnt_q - CNT_W'(1);
    end
  end

  assign timeout_hit = waiting && !accept && (to_cnt_q == CNT_W'(1));
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign timeout_hit   = 1'b0;
`endif

  // The push strobe is combinational so it can never fire against FIFO_FULL.
  assign tx_push = ((state_q == TX_LO) || (state_q == TX_HI)) && !bus.fifo_full;

  always_comb begin
    state_d      = state_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_func_d   = alu_func_q;
    alu_en_d     = 1'b0;
    cmd_err_d    = 1'b0;
    res_d        = res_q;
    is_alu_d     = is_alu_q;
    accept       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.rx_d_vld) begin
          accept = 1'b1;
          case (bus.rx_p_data)
            OP_WR: begin
              state_d  = WR_ADDR;
              is_alu_d = 1'b0;
            end
            OP_RD: begin
              state_d  = RD_ADDR;
              is_alu_d = 1'b0;
            end
            OP_ALU: begin
              state_d  = ALU_A;
              is_alu_d = 1'b1;
            end
            OP_FN: begin
              state_d  = ALU_FN;
              is_alu_d = 1'b1;
            end
            default: cmd_err_d = 1'b1;
          endcase
        end
      end
      WR_ADDR: begin
        if (bus.rx_d_vld) begin
          accept    = 1'b1;
          rf_addr_d = bus.rx_p_data[REG_FILE_ADDR_WIDTH-1:0];
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (bus.rx_d_vld) begin
          accept       = 1'b1;
          rf_wr_data_d = bus.rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = IDLE;
        end
      end
      RD_ADDR: begin
        if (bus.rx_d_vld) begin
          accept     = 1'b1;
          rf_addr_d  = bus.rx_p_data[REG_FILE_ADDR_WIDTH-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.rf_rd_data_vld) begin
          accept  = 1'b1;
          res_d   = {{(ALU_DATA_WIDTH-FRAME_WIDTH){1'b0}}, bus.rf_rd_data};
          state_d = TX_LO;
        end
      end
      ALU_A: begin
        if (bus.rx_d_vld) begin
          accept       = 1'b1;
          rf_addr_d    = '0;
          rf_wr_data_d = bus.rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = ALU_B;
        end
      end
      ALU_B: begin
        if (bus.rx_d_vld) begin
          accept       = 1'b1;
          rf_addr_d    = REG_FILE_ADDR_WIDTH'(1);
          rf_wr_data_d = bus.rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = ALU_FN;
        end
      end
      ALU_FN: begin
        if (bus.rx_d_vld) begin
          accept     = 1'b1;
          alu_func_d = bus.rx_p_data[ALU_FUNC_WIDTH-1:0];
          alu_en_d   = 1'b1;
          state_d    = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (bus.alu_out_vld) begin
          accept  = 1'b1;
          res_d   = bus.alu_out;
          state_d = TX_LO;
        end
      end
      TX_LO: begin
        if (tx_push) begin
          state_d = is_alu_q ? TX_HI : IDLE;
        end
      end
      TX_HI: begin
        if (tx_push) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_hit) begin
      state_d   = IDLE;
      cmd_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      alu_func_q   <= '0;
      alu_en_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
      res_q        <= '0;
      is_alu_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      alu_func_q   <= alu_func_d;
      alu_en_q     <= alu_en_d;
      cmd_err_q    <= cmd_err_d;
      res_q        <= res_d;
      is_alu_q     <= is_alu_d;
    end
  end

  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_wr_data = rf_wr_data_q;
  assign bus.rf_wr_en   = rf_wr_en_q;
  assign bus.rf_rd_en   = rf_rd_en_q;
  assign bus.alu_func   = alu_func_q;
  assign bus.alu_en     = alu_en_q;
  assign bus.cmd_err    = cmd_err_q;
  assign bus.tx_d_vld   = tx_push;

  // Held at the selected byte while stalled on FIFO_FULL; zero outside TX states.
  assign bus.tx_p_data = (state_q == TX_LO) ? res_q[FRAME_WIDTH-1:0] :
                         (state_q == TX_HI) ? res_q[ALU_DATA_WIDTH-1 -: FRAME_WIDTH] :
                         '0;

  assign bus.clk_gate_en = (state_q == ALU_A) || (state_q == ALU_B) ||
                           (state_q == ALU_FN) || (state_q == ALU_WAIT) ||
                           (is_alu_q && ((state_q == TX_LO) || (state_q == TX_HI)));

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
module tb_sys_cmd_ctrl;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sys_cmd_ctrl_if bus_if ();

  sys_cmd_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_cnt, rd_cnt, alu_cnt, err_cnt, full_viol;
  logic [7:0] tx_q[$];
  int tx_t[$];

  always @(posedge clk) cyc++;

  // Event monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.rf_wr_en) wr_cnt++;
      if (bus_if.rf_rd_en) rd_cnt++;
      if (bus_if.alu_en) alu_cnt++;
      if (bus_if.cmd_err) err_cnt++;
      if (bus_if.tx_d_vld) begin
        tx_q.push_back(bus_if.tx_p_data);
        tx_t.push_back(cyc);
        if (bus_if.fifo_full) full_viol++;
      end
    end
  end

  task automatic clear_mon();
    wr_cnt = 0; rd_cnt = 0; alu_cnt = 0; err_cnt = 0; full_viol = 0;
    tx_q.delete();
    tx_t.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus_if.rx_p_data = b;
    bus_if.rx_d_vld  = 1'b1;
    @(posedge clk);
    #1;
    bus_if.rx_d_vld  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.rx_p_data = '0; bus_if.rx_d_vld = 1'b0;
    bus_if.rf_rd_data = '0; bus_if.rf_rd_data_vld = 1'b0;
    bus_if.alu_out = '0; bus_if.alu_out_vld = 1'b0;
    bus_if.fifo_full = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus_if.rf_wr_en, bus_if.rf_rd_en, bus_if.alu_en, bus_if.tx_d_vld,
         bus_if.cmd_err, bus_if.clk_gate_en} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes got=%b want=000000", {bus_if.rf_wr_en, bus_if.rf_rd_en,
               bus_if.alu_en, bus_if.tx_d_vld, bus_if.cmd_err, bus_if.clk_gate_en});
    end
    checks++;
    if ({bus_if.rf_addr, bus_if.rf_wr_data, bus_if.alu_func, bus_if.tx_p_data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got=%h want=000000",
               {bus_if.rf_addr, bus_if.rf_wr_data, bus_if.alu_func, bus_if.tx_p_data});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    clear_mon();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    checks++;
    if (bus_if.rf_wr_en !== 1'b1) begin errors++; $display("FAIL wr_en got=%b want=1", bus_if.rf_wr_en); end
    checks++;
    if (bus_if.rf_addr !== 4'h5) begin errors++; $display("FAIL wr_addr got=%h want=5", bus_if.rf_addr); end
    checks++;
    if (bus_if.rf_wr_data !== 8'h3C) begin errors++; $display("FAIL wr_data got=%h want=3c", bus_if.rf_wr_data); end
    tick();
    checks++;
    if (bus_if.rf_wr_en !== 1'b0) begin errors++; $display("FAIL wr_en_width got=%b want=0", bus_if.rf_wr_en); end
    repeat (3) tick();
    checks++;
    if (wr_cnt !== 1 || err_cnt !== 0) begin
      errors++; $display("FAIL wr_counts got wr=%0d err=%0d want wr=1 err=0", wr_cnt, err_cnt);
    end
  endtask

  task automatic test_read();
    clear_mon();
    send_byte(8'hBB); send_byte(8'h05);
    checks++;
    if (bus_if.rf_rd_en !== 1'b1 || bus_if.rf_addr !== 4'h5) begin
      errors++; $display("FAIL rd_strobe got en=%b addr=%h want en=1 addr=5", bus_if.rf_rd_en, bus_if.rf_addr);
    end
    tick();
    bus_if.rf_rd_data = 8'h3C; bus_if.rf_rd_data_vld = 1'b1;
    tick();
    bus_if.rf_rd_data_vld = 1'b0;
    repeat (4) tick();
    checks++;
    if (rd_cnt !== 1 || tx_q.size() !== 1) begin
      errors++; $display("FAIL rd_counts got rd=%0d tx=%0d want rd=1 tx=1", rd_cnt, tx_q.size());
    end else begin
      checks++;
      if (tx_q[0] !== 8'h3C) begin errors++; $display("FAIL rd_tx_byte got=%h want=3c", tx_q[0]); end
    end
  endtask

  task automatic test_alu();
    clear_mon();
    send_byte(8'hCC); send_byte(8'hA9);
    checks++;
    if (bus_if.rf_wr_en !== 1'b1 || bus_if.rf_addr !== 4'h0 || bus_if.rf_wr_data !== 8'hA9) begin
      errors++; $display("FAIL alu_opa got en=%b addr=%h data=%h want en=1 addr=0 data=a9",
                         bus_if.rf_wr_en, bus_if.rf_addr, bus_if.rf_wr_data);
    end
    checks++;
    if (bus_if.clk_gate_en !== 1'b1) begin errors++; $display("FAIL alu_gate_on got=%b want=1", bus_if.clk_gate_en); end
    send_byte(8'h08);
    checks++;
    if (bus_if.rf_wr_en !== 1'b1 || bus_if.rf_addr !== 4'h1 || bus_if.rf_wr_data !== 8'h08) begin
      errors++; $display("FAIL alu_opb got en=%b addr=%h data=%h want en=1 addr=1 data=08",
                         bus_if.rf_wr_en, bus_if.rf_addr, bus_if.rf_wr_data);
    end
    send_byte(8'h02);
    checks++;
    if (bus_if.alu_en !== 1'b1 || bus_if.alu_func !== 4'h2) begin
      errors++; $display("FAIL alu_start got en=%b func=%h want en=1 func=2", bus_if.alu_en, bus_if.alu_func);
    end
    tick();
    bus_if.alu_out = 16'h00A1; bus_if.alu_out_vld = 1'b1;
    tick();
    bus_if.alu_out_vld = 1'b0;
    repeat (4) tick();
    checks++;
    if (tx_q.size() !== 2 || wr_cnt !== 2 || alu_cnt !== 1) begin
      errors++; $display("FAIL alu_counts got tx=%0d wr=%0d alu=%0d want tx=2 wr=2 alu=1",
                         tx_q.size(), wr_cnt, alu_cnt);
    end else begin
      checks++;
      if (tx_q[0] !== 8'hA1 || tx_q[1] !== 8'h00 || (tx_t[1] - tx_t[0]) !== 1) begin
        errors++; $display("FAIL alu_tx got %h,%h gap=%0d want a1,00 gap=1", tx_q[0], tx_q[1], tx_t[1] - tx_t[0]);
      end
    end
    checks++;
    if (bus_if.clk_gate_en !== 1'b0) begin errors++; $display("FAIL alu_gate_off got=%b want=0", bus_if.clk_gate_en); end
  endtask

  task automatic test_fifo_full();
    clear_mon();
    send_byte(8'hDD); send_byte(8'h00);
    checks++;
    if (bus_if.alu_en !== 1'b1 || bus_if.alu_func !== 4'h0) begin
      errors++; $display("FAIL fn_start got en=%b func=%h want en=1 func=0", bus_if.alu_en, bus_if.alu_func);
    end
    bus_if.fifo_full = 1'b1;
    tick();
    bus_if.alu_out = 16'h1234; bus_if.alu_out_vld = 1'b1;
    tick();
    bus_if.alu_out_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus_if.tx_d_vld !== 1'b0 || bus_if.tx_p_data !== 8'h34) begin
        errors++; $display("FAIL full_hold cyc%0d got vld=%b data=%h want vld=0 data=34",
                           i, bus_if.tx_d_vld, bus_if.tx_p_data);
      end
    end
    bus_if.fifo_full = 1'b0;
    repeat (4) tick();
    checks++;
    if (tx_q.size() !== 2 || full_viol !== 0) begin
      errors++; $display("FAIL full_counts got tx=%0d viol=%0d want tx=2 viol=0", tx_q.size(), full_viol);
    end else begin
      checks++;
      if (tx_q[0] !== 8'h34 || tx_q[1] !== 8'h12 || (tx_t[1] - tx_t[0]) !== 1) begin
        errors++; $display("FAIL full_tx got %h,%h gap=%0d want 34,12 gap=1", tx_q[0], tx_q[1], tx_t[1] - tx_t[0]);
      end
    end
  endtask

  task automatic test_bad_opcode();
    clear_mon();
    send_byte(8'h77);
    checks++;
    if (bus_if.cmd_err !== 1'b1) begin errors++; $display("FAIL bad_op_err got=%b want=1", bus_if.cmd_err); end
    tick();
    checks++;
    if (bus_if.cmd_err !== 1'b0) begin errors++; $display("FAIL bad_op_width got=%b want=0", bus_if.cmd_err); end
    repeat (2) tick();
    checks++;
    if (wr_cnt + rd_cnt + alu_cnt !== 0 || tx_q.size() !== 0 || err_cnt !== 1) begin
      errors++; $display("FAIL bad_op_strobes got wr=%0d rd=%0d alu=%0d tx=%0d err=%0d want 0,0,0,0,1",
                         wr_cnt, rd_cnt, alu_cnt, tx_q.size(), err_cnt);
    end
  endtask

  task automatic test_reset_abort();
    clear_mon();
    send_byte(8'hAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_byte(8'h05); send_byte(8'h3C);
    repeat (3) tick();
    checks++;
    if (wr_cnt !== 0 || err_cnt !== 2) begin
      errors++; $display("FAIL rst_abort got wr=%0d err=%0d want wr=0 err=2", wr_cnt, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_byte(8'hBB); send_byte(8'h07);
    tick();
    // frames arriving in RD_WAIT and in the TX_LO push cycle must be dropped
    bus_if.rf_rd_data = 8'h5A; bus_if.rf_rd_data_vld = 1'b1;
    bus_if.rx_p_data = 8'hAA; bus_if.rx_d_vld = 1'b1;
    tick();
    bus_if.rf_rd_data_vld = 1'b0;
    tick();
    bus_if.rx_d_vld = 1'b0;
    repeat (2) tick();
    checks++;
    if (tx_q.size() !== 1 || err_cnt !== 0 || wr_cnt !== 0) begin
      errors++; $display("FAIL drop_counts got tx=%0d err=%0d wr=%0d want 1,0,0", tx_q.size(), err_cnt, wr_cnt);
    end else begin
      checks++;
      if (tx_q[0] !== 8'h5A) begin errors++; $display("FAIL drop_tx got=%h want=5a", tx_q[0]); end
    end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h11);
    checks++;
    if (bus_if.rf_wr_en !== 1'b1 || bus_if.rf_addr !== 4'h1 || bus_if.rf_wr_data !== 8'h11) begin
      errors++; $display("FAIL b2b_write got en=%b addr=%h data=%h want en=1 addr=1 data=11",
                         bus_if.rf_wr_en, bus_if.rf_addr, bus_if.rf_wr_data);
    end
    tick();
  endtask

`ifdef SYS_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    clear_mon();
    send_byte(8'hAA);
    k = 1;
    while (bus_if.cmd_err !== 1'b1 && k < TIMEOUT + 10) begin
      tick();
      k++;
    end
    checks++;
    if (k !== TIMEOUT) begin errors++; $display("FAIL timeout_latency got=%0d want=%0d", k, TIMEOUT); end
    tick();
    checks++;
    if (bus_if.cmd_err !== 1'b0 || bus_if.clk_gate_en !== 1'b0) begin
      errors++; $display("FAIL timeout_after got err=%b gate=%b want 0,0", bus_if.cmd_err, bus_if.clk_gate_en);
    end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h11);
    checks++;
    if (bus_if.rf_wr_en !== 1'b1 || bus_if.rf_addr !== 4'h1 || bus_if.rf_wr_data !== 8'h11) begin
      errors++; $display("FAIL timeout_recover got en=%b addr=%h data=%h want en=1 addr=1 data=11",
                         bus_if.rf_wr_en, bus_if.rf_addr, bus_if.rf_wr_data);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    clear_mon();
    send_byte(8'hAA);
    repeat (200) tick();
    checks++;
    if (err_cnt !== 0) begin errors++; $display("FAIL no_timeout_err got=%0d want=0", err_cnt); end
    send_byte(8'h01); send_byte(8'h11);
    checks++;
    if (bus_if.rf_wr_en !== 1'b1 || bus_if.rf_addr !== 4'h1 || bus_if.rf_wr_data !== 8'h11) begin
      errors++; $display("FAIL no_timeout_write got en=%b addr=%h data=%h want en=1 addr=1 data=11",
                         bus_if.rf_wr_en, bus_if.rf_addr, bus_if.rf_wr_data);
    end
    tick();
  endtask
`endif

  initial begin
    clear_mon();
    test_reset();
    test_write();
    test_read();
    test_alu();
    test_fifo_full();
    test_bad_opcode();
    test_reset_abort();
    test_back_to_back();
`ifdef SYS_CTRL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys_cmd_ctrl.md
# sys_cmd_ctrl

- Command decoder between the UART receive path and the register file/ALU.
- Consumes byte frames (RX_P_DATA/RX_D_VLD), parses command sequences, and issues register-file writes/reads and ALU operations.
- Pushes results into the TX FIFO that feeds UART TX.
- Single clock domain, running on CLK alongside the register file and ALU.

## Interface
- FRAME_WIDTH, 8, byte width of RX/TX frames and register-file data
- ALU_DATA_WIDTH, 16, ALU result width
- ALU_FUNC_WIDTH, 4, ALU function code width
- REG_FILE_ADDR_WIDTH, 4, register-file address width
- TIMEOUT_CYCLES, 4096, inter-frame watchdog limit; only used when SYS_CTRL_TIMEOUT_EN is defined
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset; synchronous, active-high
- RX_P_DATA  in  FRAME_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid this cycle
- RF_RD_DATA  in  FRAME_WIDTH  register-file read data
- RF_RD_DATA_VLD  in  1  read data valid
- ALU_OUT  in  ALU_DATA_WIDTH  ALU result
- ALU_OUT_VLD  in  1  ALU result valid
- FIFO_FULL  in  1  TX FIFO cannot accept a byte
- RF_ADDR  out  REG_FILE_ADDR_WIDTH  register address
- RF_WR_EN  out  1  write strobe
- RF_RD_EN  out  1  read strobe
- RF_WR_DATA  out  FRAME_WIDTH  write data
- ALU_FUNC  out  ALU_FUNC_WIDTH  function code
- ALU_EN  out  1  ALU start strobe
- CLK_GATE_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  FRAME_WIDTH  byte pushed to the FIFO
- TX_D_VLD  out  1  FIFO write strobe
- CMD_ERR  out  1  one-cycle pulse on an unknown opcode or a timeout abort

## Operation
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FN, ALU_WAIT, TX_LO, TX_HI.
- IDLE, on RX_D_VLD, decodes the opcode:
  - 0xAA → WR_ADDR
  - 0xBB → RD_ADDR
  - 0xCC → ALU_A
  - 0xDD → ALU_FN
  - any other value → CMD_ERR pulse; remain in IDLE.
- Write command (0xAA):
  - WR_ADDR latches RX_P_DATA[REG_FILE_ADDR_WIDTH-1:0]; upper bits are ignored.
  - WR_DATA, on the next frame, drives RF_WR_EN for 1 cycle with the latched address and data, then returns to IDLE.
- Read command (0xBB):
  - RD_ADDR, on the address frame, drives RF_RD_EN for 1 cycle → RD_WAIT.
  - RD_WAIT, on RF_RD_DATA_VLD, captures the byte → TX_LO. No TX_HI is sent for reads.
- ALU with operands (0xCC):
  - ALU_A writes its frame to reg 0x0.
  - ALU_B writes its frame to reg 0x1.
  - Then → ALU_FN.
- ALU function frame (ALU_FN, entered from 0xCC or 0xDD):
  - ALU_FUNC = RX_P_DATA[ALU_FUNC_WIDTH-1:0].
  - ALU_EN pulses 1 cycle → ALU_WAIT.
  - ALU_WAIT, on ALU_OUT_VLD, captures the 16-bit result → TX_LO.
- TX_LO pushes the low byte; TX_HI pushes ALU_OUT[15:8] (ALU path only).
- CLK_GATE_EN is high in ALU_A through TX_HI for ALU commands; low otherwise.
- RX_D_VLD arriving in RD_WAIT, ALU_WAIT, TX_LO or TX_HI is dropped silently.

## Timing
- Reset values: every output is 0 and the state is IDLE. RST asserted mid-command aborts it with no further strobes.
- Each RF/ALU strobe is asserted in the cycle after the RX_D_VLD that completes its operand.
- Write command latency: RF_WR_EN fires 1 cycle after the data frame.
- FIFO push:
  - TX_D_VLD=1 only in a cycle where FIFO_FULL=0.
  - While FIFO_FULL=1, the FSM holds TX_LO/TX_HI with TX_D_VLD=0 and TX_P_DATA stable.
  - Bytes go out one per cycle, low byte first.
- RF_RD_DATA_VLD or ALU_OUT_VLD arriving in the same cycle as the strobe is not expected; validity is sampled from the next cycle on.
- Simultaneous RX_D_VLD and a TX state transition: the transition wins and the frame is dropped.

## Configuration
- SYS_CTRL_TIMEOUT_EN
  - Defined:
    - A counter runs in every state except IDLE, TX_LO and TX_HI.
    - It clears on each accepted RX_D_VLD or valid input.
    - On reaching TIMEOUT_CYCLES it pulses CMD_ERR, forces IDLE, and deasserts CLK_GATE_EN.
  - Undefined: no counter; the FSM waits indefinitely. CMD_ERR comes only from unknown opcodes.

## Test plan
- AA,05,3C → RF_WR_EN for exactly 1 cycle with RF_ADDR=5, RF_WR_DATA=0x3C; FSM back in IDLE.
- BB,05, RF_RD_DATA=0x3C → RF_RD_EN with RF_ADDR=5, then one TX_D_VLD with TX_P_DATA=0x3C.
- CC,A9,08,02, ALU_OUT=0x00A1 → writes reg0=0xA9 and reg1=0x08; ALU_EN with ALU_FUNC=2; FIFO pushes 0xA1 then 0x00 on consecutive cycles.
- DD,00, FIFO_FULL held high 5 cycles, ALU_OUT=0x1234 → no TX_D_VLD while full; then 0x34 then 0x12.
- Opcode 0x77 → 1-cycle CMD_ERR pulse, no strobes. RST asserted between AA and its address frame → no write occurs.
- SYS_CTRL_TIMEOUT_EN defined, AA then silence → CMD_ERR exactly TIMEOUT_CYCLES cycles after the opcode; a later AA,01,11 writes reg1.
